// File: rtl/mem_slave_ctrl.sv
// ---------------------------------------------------------------------------
// mem_slave_ctrl
//   Handshaked single-port memory slave with a configurable number of wait
//   states. Each accepted request costs 1+WAIT_STATES busy cycles. The
//   storage is updated and rd_data_o is loaded on the EXEC->IDLE edge.
//
// Ports
//   clk_i      in   1           clock, all logic on posedge
//   rst_i      in   1           asynchronous active-low reset
//   valid_i    in   1           request valid
//   wr_rd_i    in   1           1 = write, 0 = read
//   addr_i     in   ADDR_WIDTH  word address
//   wr_data_i  in   WIDTH       write data
//   ready_o    out  1           request accepted on a posedge when high
//   rd_data_o  out  WIDTH       data of the last completed read
//   wr_cnt_o   out  16          completed writes, saturating (optional)
//   rd_cnt_o   out  16          completed reads, saturating (optional)
//
// Build option
//   MEM_ACCESS_CNT_EN : when defined, adds wr_cnt_o / rd_cnt_o counters.
// ---------------------------------------------------------------------------
module mem_slave_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      rd_data_o
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]           wr_cnt_o,
    output logic [15:0]           rd_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    // Counter value loaded on accept; the WAIT state exits once it reaches 0,
    // giving exactly WAIT_STATES cycles in WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    // One bit wider than the address so a power-of-2 DEPTH fits.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic                  r_ready;
    logic                  w_ready_next;
    logic                  r_wr_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wr_data;
    logic [WIDTH-1:0]      r_rd_data;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic w_accept;
    logic w_exec;
    logic w_addr_ok;
    logic w_wr_commit;
    logic w_rd_commit;

    // r_ready is only ever high in IDLE, so it alone qualifies an accept.
    assign w_accept    = valid_i & r_ready;
    assign w_exec      = (r_state == ST_EXEC);
    assign w_addr_ok   = ({1'b0, r_addr} < DEPTH_EXT);
    assign w_wr_commit = w_exec & r_wr_rd & w_addr_ok;
    assign w_rd_commit = w_exec & ~r_wr_rd;

    assign ready_o   = r_ready;
    assign rd_data_o = r_rd_data;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_ready    <= w_ready_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = ST_EXEC;
                    end else begin
                        w_state_next    = ST_WAIT;
                        w_wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Registered ready: it follows the state we are about to enter.
        w_ready_next = (w_state_next == ST_IDLE);
    end

    // Request capture; later input changes cannot disturb the transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_rd   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr_rd   <= wr_rd_i;
            r_addr    <= addr_i;
            r_wr_data <= wr_data_i;
        end
    end

    // Storage. Cleared on reset, so it is built from flops rather than RAM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_mem[r_addr] <= r_wr_data;
        end
    end

    // Read data holds until the next read completes; out-of-range reads give 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_data <= '0;
        end else if (w_rd_commit) begin
            r_rd_data <= w_addr_ok ? r_mem[r_addr] : '0;
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_cnt <= 16'd0;
            r_rd_cnt <= 16'd0;
        end else if (w_exec) begin
            if (r_wr_rd && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (!r_wr_rd && (r_rd_cnt != 16'hFFFF)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign wr_cnt_o = r_wr_cnt;
    assign rd_cnt_o = r_rd_cnt;
`endif

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_slave_ctrl
//   Driver issues directed and random requests and pushes each accepted one
//   into a scoreboard queue. The monitor pops an entry whenever ready_o
//   rises (a transaction completed), applies it to a plain array model of the
//   memory and compares rd_data_o, latency and (optionally) the counters.
// ---------------------------------------------------------------------------
module tb_mem_slave_ctrl;

    localparam int WS = 3;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        int          acc;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        wr_rd_i = 1'b0;
    logic [3:0]  addr_i = 4'd0;
    logic [15:0] wr_data_i = 16'd0;
    logic        ready_o;
    logic [15:0] rd_data_o;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] wr_cnt_o;
    logic [15:0] rd_cnt_o;
`endif

    mem_slave_ctrl #(
        .WIDTH       (16),
        .DEPTH       (16),
        .WAIT_STATES (WS)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .wr_rd_i   (wr_rd_i),
        .addr_i    (addr_i),
        .wr_data_i (wr_data_i),
        .ready_o   (ready_o),
        .rd_data_o (rd_data_o)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .wr_cnt_o  (wr_cnt_o),
        .rd_cnt_o  (rd_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    txn_t sb[$];
    bit   done = 1'b0;
    bit   fin = 1'b0;

    initial forever @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    initial begin : monitor
        logic [15:0] model_mem [16];
        logic [15:0] last_rd;
        int          wr_cnt;
        int          rd_cnt;
        bit          prev_ready;
        bit          in_rst;
        bit          post_rel;
        txn_t        e;
        for (int i = 0; i < 16; i++) model_mem[i] = 16'd0;
        last_rd = 16'd0; wr_cnt = 0; rd_cnt = 0;
        prev_ready = 1'b0; in_rst = 1'b0; post_rel = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                chk("reset_ready", 32'(ready_o), 32'd0);
                chk("reset_rd_data", 32'(rd_data_o), 32'd0);
`ifdef MEM_ACCESS_CNT_EN
                chk("reset_wr_cnt", 32'(wr_cnt_o), 32'd0);
                chk("reset_rd_cnt", 32'(rd_cnt_o), 32'd0);
`endif
                sb.delete();
                for (int i = 0; i < 16; i++) model_mem[i] = 16'd0;
                last_rd = 16'd0; wr_cnt = 0; rd_cnt = 0;
                in_rst = 1'b1; post_rel = 1'b0;
            end else if (in_rst) begin
                // Release happened after the last posedge: still not ready.
                chk("ready_low_at_release", 32'(ready_o), 32'd0);
                in_rst = 1'b0;
                post_rel = 1'b1;
            end else if (post_rel) begin
                chk("ready_one_edge_after_release", 32'(ready_o), 32'd1);
                post_rel = 1'b0;
            end else if (ready_o && !prev_ready) begin
                chk("completion_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.acc), 32'(1 + WS));
                    if (e.wr) begin
                        model_mem[e.addr] = e.data;
                        wr_cnt = (wr_cnt < 65535) ? wr_cnt + 1 : wr_cnt;
                        chk("write_keeps_rd_data", 32'(rd_data_o), 32'(last_rd));
                    end else begin
                        last_rd = model_mem[e.addr];
                        rd_cnt = (rd_cnt < 65535) ? rd_cnt + 1 : rd_cnt;
                        chk("read_data", 32'(rd_data_o), 32'(last_rd));
                    end
`ifdef MEM_ACCESS_CNT_EN
                    chk("wr_cnt", 32'(wr_cnt_o), 32'(wr_cnt));
                    chk("rd_cnt", 32'(rd_cnt_o), 32'(rd_cnt));
`endif
                    $display("txn %s addr=%0d data=%04h rd_data=%04h done@%0d",
                             e.wr ? "WR" : "RD", e.addr, e.data, rd_data_o, cyc);
                end
            end
            prev_ready = rst_i ? ready_o : 1'b0;
            if (done && !fin) begin
                chk("scoreboard_drained", 32'(sb.size()), 32'd0);
                fin = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ driver
    task automatic scramble();
        valid_i   = 1'($urandom_range(0, 1));
        wr_rd_i   = 1'($urandom_range(0, 1));
        addr_i    = 4'($urandom);
        wr_data_i = 16'($urandom);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (ready_o) return;
            scramble();
        end
        $display("FAIL ready_timeout: ready_o stuck low, expected high within 100 cycles");
        $fatal(1, "ready timeout");
    endtask

    task automatic issue(input bit wr, input bit [3:0] a, input bit [15:0] d);
        wait_ready();
        valid_i = 1'b1; wr_rd_i = wr; addr_i = a; wr_data_i = d;
        sb.push_back('{wr: wr, addr: a, data: d, acc: cyc + 1});
        @(posedge clk_i); #1;
        scramble();
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #2;
            scramble();
        end
        rst_i = 1'b1;
        valid_i = 1'b0;
    endtask

    initial begin : driver
        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;

        // Basic write then read
        issue(1'b1, 4'd4, 16'hA5A5);
        issue(1'b0, 4'd4, 16'h0000);
        issue(1'b1, 4'd7, 16'h1234);
        idle(2);
        issue(1'b0, 4'd7, 16'h0000);

        // Fill all with FFFF and read back
        for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 16'hFFFF);
        for (int i = 0; i < 16; i++) issue(1'b0, 4'(i), 16'h0000);

        // Fresh reset clears storage
        wait_ready();
        do_reset();
        issue(1'b0, 4'd15, 16'h0000);

        // Reset during the wait of a write aborts it
        issue(1'b1, 4'd3, 16'hBEEF);
        issue(1'b0, 4'd3, 16'h0000);
        issue(1'b1, 4'd3, 16'h5A5A);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #2;
            scramble();
        end
        rst_i = 1'b1;
        valid_i = 1'b0;
        issue(1'b0, 4'd3, 16'h0000);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        wait_ready();
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        done = 1'b1;
        for (int n = 0; n < 10 && !fin; n++) @(posedge clk_i);
        if (!fin) $display("FAIL monitor_finish: monitor did not acknowledge end of test");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
